// File: rtl/theta_pkg.sv
// theta_pkg: shared sizes, FSM encoding and slice bit indexing for the theta stage.
package theta_pkg;
  localparam int SLICE_W = 25;
  localparam int DEPTH = 64;
  localparam int CNT_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PARITY, APPLY, DONE} state_e;
  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction
endpackage

// File: rtl/theta_counter.sv
// theta_counter: slice address counter with enable, sync clear and carry-out.
module theta_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    carry = en & (&cnt_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign value = cnt_q;
endmodule

// File: rtl/theta_parity_ram.sv
// theta_parity_ram: per-slice 5-bit column parity store, one write port, reads at z and z-1.
module theta_parity_ram
  import theta_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [4:0]       wdata,
  input  logic [CNT_W-1:0] raddr_a,
  input  logic [CNT_W-1:0] raddr_b,
  output logic [4:0]       rdata_a,
  output logic [4:0]       rdata_b
);
  logic [4:0] mem_q [DEPTH];
  logic [4:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/theta_top.sv
// theta_top: two-pass theta step; pass 1 gathers column parities, pass 2 writes mixed slices back.
module theta_top
  import theta_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               theta_en,
  input  logic [SLICE_W-1:0] line_in,
  output logic [CNT_W-1:0]   cnt_value,
  output logic               write_enable,
  output logic [SLICE_W-1:0] write_value,
  output logic               donee
);
  state_e state_q, state_d;
  logic cnt_en, carry;
  logic [CNT_W-1:0] cnt, cnt_m1;
  logic [4:0] par_w, c_z, c_zm1, mix_x;
  logic [SLICE_W-1:0] mix;
  assign cnt_en = (state_q == PARITY) || (state_q == APPLY);
  theta_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .en(cnt_en), .clr(!cnt_en), .value(cnt), .carry(carry)
  );
  assign cnt_m1 = cnt - 1'b1;
  theta_parity_ram u_par (
    .clk(clk), .rst(rst), .we(state_q == PARITY), .waddr(cnt), .wdata(par_w),
    .raddr_a(cnt), .raddr_b(cnt_m1), .rdata_a(c_z), .rdata_b(c_zm1)
  );
  always_comb begin
    par_w = '0;
    mix_x = '0;
    mix = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) par_w[x] = par_w[x] ^ line_in[bit_idx(x, y)];
      mix_x[x] = c_z[(x + 4) % 5] ^ c_zm1[(x + 1) % 5];
    end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) mix[bit_idx(x, y)] = mix_x[x];
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (theta_en) state_d = PARITY;
      PARITY: if (carry) state_d = APPLY;
      APPLY:  if (carry) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  assign cnt_value = cnt;
  assign write_enable = state_q == APPLY;
  assign write_value = write_enable ? line_in ^ mix : '0;
  assign donee = state_q == DONE;
endmodule

// File: tb/tb_theta_top.sv
// tb_theta_top: scoreboard bench; stimulus queues expected writes, a negedge monitor checks them.
module tb_theta_top;
  import theta_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic theta_en = 1'b0;
  logic [24:0] line_in;
  logic [5:0] cnt_value;
  logic write_enable;
  logic [24:0] write_value;
  logic donee;
  always #5 clk = ~clk;
  theta_top dut (
    .clk(clk), .rst(rst), .theta_en(theta_en), .line_in(line_in),
    .cnt_value(cnt_value), .write_enable(write_enable),
    .write_value(write_value), .donee(donee)
  );
  logic [24:0] mem [64];
  logic ld_clr = 1'b0;
  logic ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [24:0] ld_data = '0;
  assign line_in = mem[cnt_value];
  always @(posedge clk) begin
    if (ld_clr) for (int i = 0; i < 64; i++) mem[i] <= '0;
    if (ld_en) mem[ld_addr] <= ld_data;
    if (write_enable) mem[cnt_value] <= write_value;
  end
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_ec = -1;
  logic [30:0] exp_q[$];
  logic [30:0] mon_e;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (write_enable) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", cnt_value, write_value);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(cnt_value), 32'(mon_e[30:25]));
        check("wr_data", 32'(write_value), 32'(mon_e[24:0]));
      end
    end
    if (donee) begin
      done_cnt++;
      done_ec = ecount;
    end
  end
  task automatic load(input int a, input logic [24:0] v);
    @(negedge clk);
    ld_clr = 1'b1;
    ld_en = a >= 0;
    ld_addr = 6'(a);
    ld_data = v;
    @(negedge clk);
    ld_clr = 1'b0;
    ld_en = 1'b0;
  endtask
  task automatic push_pass(input int a1, input logic [24:0] v1, input int a2, input logic [24:0] v2, input int n);
    for (int z = 0; z < n; z++)
      exp_q.push_back({6'(z), z == a1 ? v1 : z == a2 ? v2 : 25'd0});
  endtask
  task automatic start(output int k);
    @(negedge clk);
    theta_en = 1'b1;
    @(posedge clk);
    #1 k = ecount;
    @(negedge clk);
    theta_en = 1'b0;
  endtask
  task automatic wait_done(input string name, input int k, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      #1 n++;
    end
    check({name, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
    check({name, "_done_at"}, 32'(done_ec), 32'(k + 128));
  endtask
  task automatic run(input string name, input int la, input logic [24:0] lv,
                     input int a1, input logic [24:0] v1, input int a2, input logic [24:0] v2);
    int k, d0, w0;
    load(la, lv);
    push_pass(a1, v1, a2, v2, 64);
    d0 = done_cnt;
    w0 = wr_cnt;
    start(k);
    wait_done(name, k, d0);
    @(negedge clk);
    #1;
    check({name, "_writes"}, 32'(wr_cnt - w0), 32'd64);
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    int k, d0, w0, d1, n;
    repeat (3) @(negedge clk);
    check("rst_cnt_value", 32'(cnt_value), 32'd0);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_write_value", 32'(write_value), 32'd0);
    check("rst_donee", 32'(donee), 32'd0);
    rst = 1'b1;
    run("zero", -1, 25'd0, -1, 25'd0, -1, 25'd0);
    run("s0", 0, 25'h1, 0, 25'h0210843, 1, 25'h1084210);
    check("s0_mem0", 32'(mem[0]), 32'h0210843);
    run("s63", 63, 25'h1, 63, 25'h0210843, 0, 25'h1084210);
    run("s5", 5, 25'h21, 5, 25'h21, -1, 25'd0);
    // Stray starts inside PARITY and APPLY must not disturb the pass.
    load(0, 25'h1);
    push_pass(0, 25'h0210843, 1, 25'h1084210, 64);
    d0 = done_cnt;
    w0 = wr_cnt;
    start(k);
    repeat (10) @(negedge clk);
    theta_en = 1'b1;
    @(negedge clk);
    theta_en = 1'b0;
    repeat (70) @(negedge clk);
    theta_en = 1'b1;
    @(negedge clk);
    theta_en = 1'b0;
    wait_done("ign", k, d0);
    repeat (150) @(negedge clk);
    #1;
    check("ign_done_total", 32'(done_cnt), 32'(d0 + 1));
    check("ign_writes", 32'(wr_cnt - w0), 32'd64);
    check("ign_idle_cnt", 32'(cnt_value), 32'd0);
    // Held start: second pass samples theta_en two edges after the donee cycle.
    load(-1, 25'd0);
    push_pass(-1, 25'd0, -1, 25'd0, 128);
    d0 = done_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    theta_en = 1'b1;
    @(posedge clk);
    #1 k = ecount;
    wait_done("held1", k, d0);
    d1 = done_ec;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    theta_en = 1'b0;
    wait_done("held2", k + 130, d0 + 1);
    check("held_spacing", 32'(done_ec - d1), 32'd130);
    @(negedge clk);
    #1;
    check("held_writes", 32'(wr_cnt - w0), 32'd128);
    check("held_q_empty", 32'(exp_q.size()), 32'd0);
    // Reset in the middle of APPLY: only addresses 0..4 get written.
    load(0, 25'h1);
    push_pass(0, 25'h0210843, 1, 25'h1084210, 5);
    d0 = done_cnt;
    w0 = wr_cnt;
    start(k);
    n = 0;
    while (ecount < k + 69 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    #1 rst = 1'b0;
    #1;
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_donee", 32'(donee), 32'd0);
    check("mid_rst_cnt", 32'(cnt_value), 32'd0);
    check("mid_rst_wv", 32'(write_value), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'(d0));
    check("mid_rst_writes", 32'(wr_cnt - w0), 32'd5);
    check("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);
    check("mid_rst_idle_cnt", 32'(cnt_value), 32'd0);
    run("after_rst", 63, 25'h1, 63, 25'h0210843, 0, 25'h1084210);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
